uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Serial UART receiver plus receive FIFO; directly upstream of the CPU core's UART read port.
- Deserializes the rxd line (8N1) into bytes and buffers them.
- Presents them to the core as a show-ahead FIFO: empty / data / rdreq, matching the core's uart_empty, uart_in and uart_rdreq.
- Sticky error flags are readable for debug and 7-segment display.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rxd  input  1  asynchronous serial line, idle high
- rdreq  input  1  pop head entry this cycle
- rdata  output  8  head entry (show-ahead), valid while empty=0
- empty  output  1  FIFO holds no bytes
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
- count  output  DEPTH_LOG2+1  number of stored bytes
- frame_err  output  1  sticky: a byte with stop bit = 0 was received
- overflow  output  1  sticky: a byte arrived while full
- err_clr  input  1  synchronous clear of frame_err and overflow

Behaviour:
- Reset (rst_n=0, async):
  - rx FSM to IDLE; read/write pointers and count to 0.
  - empty=1, full=0, count=0, frame_err=0, overflow=0, rdata=8'h00.
  - Synchronizer flops to 1.
  - Reset mid-frame discards the partial byte; after release, reception resumes only at the next falling edge.
- Input sync: rxd passes through 2 flops (rxd_s); all FSM decisions use rxd_s.
- Rx FSM states IDLE, START, DATA, STOP; one bit counter cnt (16 bit), one bit index (3 bit):
  - IDLE: on rxd_s=0 go to START, cnt=0.
  - START: at cnt=CLKS_PER_BIT/2-1, resample.
    - rxd_s=0: go to DATA, cnt=0, idx=0.
    - rxd_s=1: glitch, back to IDLE, no byte.
  - DATA: at cnt=CLKS_PER_BIT-1, shift rxd_s into shreg bit idx (LSB first) and reset cnt.
    - After idx=7 go to STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample stop bit.
    - 1: push shreg.
    - 0: set frame_err, do not push.
    - Either way return to IDLE.
  - A new start bit is accepted from the cycle after STOP ends.
- Push: 1-cycle internal wr pulse.
  - If full and no pop in the same cycle: byte dropped, overflow set, FIFO unchanged.
- FIFO:
  - Register array indexed by pointers of DEPTH_LOG2 bits; pointers wrap modulo depth.
  - rdata = mem[rd_ptr] combinational from registered storage.
- Pop: rdreq=1 and empty=0 advances rd_ptr on the clock edge.
  - rdreq while empty is ignored: no pointer move, no error.
- Simultaneous push and pop in one cycle:
  - Both occur and count is unchanged.
  - When full, the pop frees the slot so the push succeeds, with no overflow.
  - When empty, the pop is ignored and the push occurs.
- Push latency: the byte is visible (empty=0, rdata=byte) the cycle after the STOP sample edge.
- Flags:
  - empty = (count==0), full = (count==2**DEPTH_LOG2), both registered alongside count.
- Error clear: err_clr clears both sticky flags.
  - If err_clr coincides with a new error event, the set wins.

Test Plan:
- Reset, then frame 0x55 on rxd with CLKS_PER_BIT=8 -> ~81 clk later empty=0, rdata=8'h55, count=1; one rdreq pulse -> empty=1, count=0.
- Back-to-back frames 0x01, 0x80, 0xA5 with no idle gap -> popped in order 01, 80, A5; frame_err=0.
- 17 frames 0x00..0x10 with no reads, DEPTH_LOG2=4 -> full=1, count=16, overflow=1; pops return 00..0F; 0x10 is lost.
- Frame 0x3C with stop bit driven 0 -> no push, empty stays 1, frame_err=1; err_clr pulse -> frame_err=0.
- rxd low pulse of 2 clk (CLKS_PER_BIT=8) -> FSM returns to IDLE, no byte, no error flag.
- FIFO full and rdreq in the same cycle a new byte 0x77 completes -> count stays 16, overflow=0; 0x77 becomes the last entry read.
- rst_n asserted at DATA bit 4, then a full 0x9E frame -> only 0x9E is stored, count=1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle between the receive FIFO and the core's UART read port.
// The FIFO side is the slave (drives data/status); the core side is the master (drives rdreq).
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rdreq;
    logic [7:0]            rdata;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;

    modport master (output rdreq, input rdata, empty, full, count);
    modport slave  (input rdreq, output rdata, empty, full, count);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead register FIFO, with sticky frame-error
// and overflow flags for debug.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    input  logic err_clr,
    output logic frame_err,
    output logic overflow,
    uart_rx_fifo_if.slave rd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0]           HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]           BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  idx, idx_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        push_req, ferr_set;
    logic        rxd_m, rxd_s;

    // Synchronizer presets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            // NOTE: non-blocking so rxd_s takes the old rxd_m, giving two real flop stages.
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        idx_nx   = idx;
        shreg_nx = shreg;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rxd_s) state_nx = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx          = '0;
                    shreg_nx[idx]   = rxd_s;
                    idx_nx          = idx + 3'd1;
                    if (idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    if (rxd_s) push_req = 1'b1;
                    else       ferr_set = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_nx;
    logic                  do_pop, do_push, ovf_set;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop   = rd.rdreq && !rd.empty;
    assign do_push  = push_req && (!rd.full || do_pop);
    assign ovf_set  = push_req && !do_push;
    assign rd.rdata = mem[rd_ptr];

    always_comb begin
        count_nx = rd.count;
        if (do_push && !do_pop)      count_nx = rd.count + CNT_ONE;
        else if (!do_push && do_pop) count_nx = rd.count - CNT_ONE;
    end

    // NOTE: storage is reset because rdata reads it combinationally and must be 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd.count  <= '0;
            rd.empty  <= 1'b1;
            rd.full   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            rd.count <= count_nx;
            rd.empty <= (count_nx == '0);
            rd.full  <= (count_nx == CNT_FULL);
            // A new error event wins over a coincident clear.
            if (ferr_set)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovf_set)      overflow  <= 1'b1;
            else if (err_clr) overflow  <= 1'b0;
        end
    end
endmodule
